// File: rtl/serial_csa_adder_pkg.sv
// Shared types and constants for the serial carry-select adder.
// Optional feature macro: SERIAL_CSA_OVF_EN (signed overflow output).
package serial_csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 2;

    function automatic int clog2(input int unsigned v);
        int unsigned x;
        int          r;
        x = (v > 1) ? v - 1 : 0;
        r = 0;
        while (x > 0) begin
            r++;
            x >>= 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_csa_adder_if.sv
// Request/result bundle for serial_csa_adder.
// Optional feature macro: SERIAL_CSA_OVF_EN adds the ovf signal.
interface serial_csa_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_CSA_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_csa_adder_csa2_slice.sv
// Combinational 2-bit carry-select cell: both carry-in results precomputed, muxed by c0.
// Optional feature macro: SERIAL_CSA_OVF_EN exposes the carry into the upper bit (cmsb).
module csa2_slice (
    input  logic a1,
    input  logic a0,
    input  logic b1,
    input  logic b0,
    input  logic c0,
    output logic c1,
    output logic s1,
`ifdef SERIAL_CSA_OVF_EN
    output logic s0,
    output logic cmsb
`else
    output logic s0
`endif
);
    logic [2:0] r_c0;
    logic [2:0] r_c1;

    always_comb begin
        r_c0 = {1'b0, a1, a0} + {1'b0, b1, b0};
        r_c1 = {1'b0, a1, a0} + {1'b0, b1, b0} + 3'd1;
        {c1, s1, s0} = c0 ? r_c1 : r_c0;
    end

`ifdef SERIAL_CSA_OVF_EN
    // Carry into the upper bit recovered from its sum bit.
    assign cmsb = a1 ^ b1 ^ s1;
`endif

endmodule

// File: rtl/serial_csa_adder.sv
// Multi-cycle WIDTH-bit adder streaming two bits per clock through csa2_slice.
// Optional feature macro: SERIAL_CSA_OVF_EN enables the registered signed-overflow output.
module serial_csa_adder
    import serial_csa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_csa_adder_if.slave  bus
);
    localparam int STEPS = WIDTH / SLICE_W;
    localparam int CW    = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH+1:0] sum_cat;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             c1;
    logic             s1;
    logic             s0;
`ifdef SERIAL_CSA_OVF_EN
    logic             cmsb;
    logic             ovf_q;
`endif

    csa2_slice u_slice (
        .a1   (a_sh[1]),
        .a0   (a_sh[0]),
        .b1   (b_sh[1]),
        .b0   (b_sh[0]),
        .c0   (carry),
        .c1   (c1),
        .s1   (s1),
`ifdef SERIAL_CSA_OVF_EN
        .s0   (s0),
        .cmsb (cmsb)
`else
        .s0   (s0)
`endif
    );

    assign sum_cat = {s1, s0, sum_sh};
    assign sum_nxt = sum_cat[WIDTH+1:2];

    // Result outputs are separate registers so they hold across the accept edge
    // and only start showing partial values from the first RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cout_q <= 1'b0;
`ifdef SERIAL_CSA_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    carry  <= c1;
                    sum_sh <= sum_nxt;
                    sum_q  <= sum_nxt;
                    cout_q <= c1;
                    a_sh   <= a_sh >> SLICE_W;
                    b_sh   <= b_sh >> SLICE_W;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(STEPS - 1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
`ifdef SERIAL_CSA_OVF_EN
                        ovf_q  <= cmsb ^ c1;
`endif
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_CSA_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_csa_adder.sv
// Directed-table, corner-sequence and random checks for serial_csa_adder (WIDTH=8).
// Optional feature macro: SERIAL_CSA_OVF_EN adds ovf checks.
module tb_serial_csa_adder;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    serial_csa_adder_if #(.WIDTH(8)) bus ();

    serial_csa_adder #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cur_ovf();
`ifdef SERIAL_CSA_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Issues one operation; b2b means we are already at the negedge where done was seen.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input bit b2b, output int lat, output int busy_cnt,
                          output logic [7:0] rs, output logic rc, output logic ro);
        if (!b2b) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.cin   = tc;
        lat       = -1;
        busy_cnt  = 0;
        for (int unsigned k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a     = '0;
                bus.b     = '0;
                bus.cin   = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = int'(k) - 1;
                break;
            end
        end
        rs = bus.sum;
        rc = bus.cout;
        ro = cur_ovf();
    endtask

    vec_t        vecs [10];
    int          lat;
    int          bcnt;
    logic [7:0]  rs;
    logic        rc;
    logic        ro;
    logic [8:0]  full;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rcin;
    bit          seen_done;
    bit          b2b;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[7] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_sum",  32'(bus.sum),  32'd0);
        chk("reset_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_CSA_OVF_EN
        chk("reset_ovf",  32'(bus.ovf),  32'd0);
`endif

        for (int unsigned i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, lat, bcnt, rs, rc, ro);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd4);
            chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].cout));
`ifdef SERIAL_CSA_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].ovf));
`endif
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
        end

        // Back-to-back: start held in DONE, result must hold until first RUN edge.
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bcnt, rs, rc, ro);
        chk("b2b_first_sum", 32'(rs), 32'hFF);
        chk("b2b_first_cout", 32'(rc), 32'd1);
        bus.start = 1'b1;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_done_single", 32'(bus.done), 32'd0);
        chk("b2b_busy_after_accept", 32'(bus.busy), 32'd1);
        chk("b2b_sum_held", 32'(bus.sum), 32'hFF);
        chk("b2b_cout_held", 32'(bus.cout), 32'd1);
        lat = -1;
        for (int unsigned k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = int'(k) - 1;
                break;
            end
        end
        chk("b2b_latency", 32'(lat), 32'd4);
        chk("b2b_second_sum", 32'(bus.sum), 32'h00);
        chk("b2b_second_cout", 32'(bus.cout), 32'd0);

        // Start during RUN is ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        bus.cin   = 1'b0;
        lat       = -1;
        for (int unsigned k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start = (k == 2);
            bus.a     = (k == 2) ? 8'hFF : 8'h00;
            bus.b     = 8'h00;
            if (bus.done) begin
                lat = int'(k) - 1;
                break;
            end
        end
        bus.start = 1'b0;
        chk("ignore_latency", 32'(lat), 32'd4);
        chk("ignore_sum", 32'(bus.sum), 32'h30);
        chk("ignore_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        chk("ignore_no_restart", 32'(bus.busy), 32'd0);

        // Reset in the middle of RUN.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_sum",  32'(bus.sum),  32'd0);
        chk("rst_mid_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_CSA_OVF_EN
        chk("rst_mid_ovf",  32'(bus.ovf),  32'd0);
`endif
        seen_done = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        chk("rst_mid_no_done", 32'(seen_done), 32'd0);

        // Random sweep, mixing idle gaps and back-to-back starts.
        b2b = 1'b0;
        for (int unsigned i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rcin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rcin};
            run_op(ra, rb, rcin, b2b, lat, bcnt, rs, rc, ro);
            chk("rand_latency", 32'(lat), 32'd4);
            chk("rand_sum", {23'd0, rc, rs}, {23'd0, full});
`ifdef SERIAL_CSA_OVF_EN
            chk("rand_ovf", 32'(ro), 32'((ra[7] == rb[7]) && (full[7] != ra[7])));
`endif
            b2b = (lat == 4) && ($urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
